// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word over valid/ready
// and drives it one bit per clock with a valid strobe and an end-of-word pulse.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy,
  output logic [0:0]       state_dbg
);

  // Handshake: a word transfers on a rising edge where din_valid && din_ready.
  // din_ready never depends on din_valid; upstream holds din until accepted.

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [0:0]      S_IDLE   = 1'b0;
  localparam logic [0:0]      S_SHIFT  = 1'b1;

  logic [0:0]       state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             at_last;
  logic             accept;
  logic             head_n;

  assign at_last   = (state == S_SHIFT) && (cnt == CNT_LAST);
  assign din_ready = !rst && ((state == S_IDLE) || at_last);
  assign accept    = din_valid && din_ready;
  assign busy      = (state == S_SHIFT);
  assign state_dbg = state;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    if (accept) begin
      // Loading on the last bit keeps the serial stream gapless.
      state_n = S_SHIFT;
      cnt_n   = '0;
      shreg_n = din;
    end else if (state == S_SHIFT) begin
      if (at_last) begin
        state_n = S_IDLE;
        cnt_n   = '0;
        shreg_n = '0;
      end else begin
        cnt_n = cnt + 1'b1;
        if (MSB_FIRST) shreg_n = shreg << 1;
        else           shreg_n = shreg >> 1;
      end
    end
  end

  assign head_n = MSB_FIRST ? shreg_n[WIDTH-1] : shreg_n[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      last       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      sout       <= (state_n == S_SHIFT) && head_n;
      sout_valid <= (state_n == S_SHIFT);
      last       <= (state_n == S_SHIFT) && (cnt_n == CNT_LAST);
    end
  end

endmodule
